ps2_scancode_source: RTL and testbench

- Front end that produces the byte stream the rsa block consumes on its keyboard-side interface: ps2_data, ps2_valid, ps2_done and ps2_reset.
- Deserializes raw PS/2 keyboard frames from the pad lines and filters out key releases.
- Maps Enter to a done strobe and Esc to a reset strobe; forwards all other make codes as one-cycle byte strobes.

---
 rtl/ps2_scancode_source.sv | 168 ++++++++++++++++
 tb/tb_ps2_scancode_source.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_source.sv
// PS/2 keyboard front end: deserializes frames, drops key releases, maps Enter/Esc to strobes.
// Latency: strobe one clk after the stop-bit sample event; no backpressure, strobes are fire-and-forget.
module ps2_scancode_source #(
    parameter int         FILTER_LEN     = 4,
    parameter int         TIMEOUT_CYCLES = 5000,
    parameter logic [7:0] ENTER_CODE     = 8'h5A,
    parameter logic [7:0] ESC_CODE       = 8'h76
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] ps2_data_o,
    output logic       ps2_valid_o,
    output logic       ps2_done_o,
    output logic       ps2_reset_o,
    output logic       frame_err_o
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state_q, state_d;
    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          fclk_q, fclk_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          brk_q, brk_d, ext_q, ext_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d, done_q, done_d, reset_q, reset_d, err_q, err_d;
    logic          filt_flip, sample;

    // The filtered level flips on the FILTER_LEN-th consecutive disagreeing cycle.
    assign filt_flip = (clk_s2_q != fclk_q) && (fcnt_q == FW'(FILTER_LEN - 1));
    assign sample    = filt_flip && fclk_q;

    always_comb begin
        state_d  = state_q;
        fclk_d   = fclk_q;
        fcnt_d   = '0;
        tcnt_d   = tcnt_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        brk_d    = brk_q;
        ext_d    = ext_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        reset_d  = 1'b0;
        err_d    = 1'b0;

        if (filt_flip) begin
            fclk_d = clk_s2_q;
        end else if (clk_s2_q != fclk_q) begin
            fcnt_d = fcnt_q + FW'(1);
        end

        if (state_q != IDLE && !sample) begin
            if (tcnt_q == TW'(TIMEOUT_CYCLES)) begin
                state_d = IDLE;
                err_d   = 1'b1;
                tcnt_d  = '0;
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end

        if (sample) begin
            tcnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (!dat_s2_q) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d  = {dat_s2_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    // Odd parity: data plus parity bit must carry an odd number of ones.
                    if (!dat_s2_q || !(^{shift_q, par_q})) begin
                        err_d = 1'b1;
                    end else if (shift_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else if (shift_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (brk_q) begin
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                    end else begin
                        ext_d = 1'b0;
                        if (shift_q == ENTER_CODE) begin
                            done_d = 1'b1;
                        end else if (shift_q == ESC_CODE) begin
                            reset_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            data_d  = shift_q;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            fclk_q   <= 1'b1;
            fcnt_q   <= '0;
            tcnt_q   <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            brk_q    <= 1'b0;
            ext_q    <= 1'b0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            reset_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            clk_s1_q <= ps2_clk_i;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_dat_i;
            dat_s2_q <= dat_s1_q;
            fclk_q   <= fclk_d;
            fcnt_q   <= fcnt_d;
            tcnt_q   <= tcnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            brk_q    <= brk_d;
            ext_q    <= ext_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            reset_q  <= reset_d;
            err_q    <= err_d;
        end
    end

    assign ps2_data_o  = data_q;
    assign ps2_valid_o = valid_q;
    assign ps2_done_o  = done_q;
    assign ps2_reset_o = reset_q;
    assign frame_err_o = err_q;
endmodule

// File: tb/tb_ps2_scancode_source.sv
// Directed plus randomized PS/2 frames against a scancode-level model of the keyboard decoder.
module tb_ps2_scancode_source;
    localparam int TIMEOUT = 5000;
    localparam int HALF    = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk_i = 1'b1;
    logic       ps2_dat_i = 1'b1;
    logic [7:0] ps2_data_o;
    logic       ps2_valid_o, ps2_done_o, ps2_reset_o, frame_err_o;

    ps2_scancode_source #(
        .FILTER_LEN(4), .TIMEOUT_CYCLES(TIMEOUT), .ENTER_CODE(8'h5A), .ESC_CODE(8'h76)
    ) dut (
        .clk(clk), .rst(rst), .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
        .ps2_data_o(ps2_data_o), .ps2_valid_o(ps2_valid_o), .ps2_done_o(ps2_done_o),
        .ps2_reset_o(ps2_reset_o), .frame_err_o(frame_err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_valid = 0, n_done = 0, n_rst = 0, n_err = 0, n_excl = 0, n_wide = 0;
    int t_any = 0, t_fall = 0;
    logic [7:0] last_data = 8'h00;
    logic prev_any = 1'b0;

    // Reference state: decoder flags and the last forwarded byte.
    bit m_brk = 0, m_ext = 0;
    logic [7:0] m_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        int s;
        s = int'(ps2_valid_o) + int'(ps2_done_o) + int'(ps2_reset_o) + int'(frame_err_o);
        if (ps2_valid_o) begin n_valid++; last_data = ps2_data_o; end
        if (ps2_done_o)  n_done++;
        if (ps2_reset_o) n_rst++;
        if (frame_err_o) n_err++;
        if (s > 1) n_excl++;
        if (s > 0 && prev_any) n_wide++;
        if (s > 0) t_any = cyc;
        prev_any = (s > 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bits are sent LSB first: bit0 = start bit.
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_dat_i = bits[i];
            wait_clk(HALF / 2);
            ps2_clk_i = 1'b0;
            t_fall = cyc;
            wait_clk(HALF);
            ps2_clk_i = 1'b1;
            wait_clk(HALF / 2);
        end
        ps2_dat_i = 1'b1;
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit flip);
        logic p;
        p = ~(^b) ^ flip;
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic model(input logic [7:0] b, input bit bad,
                         output int ev, output int ed, output int er, output int ee);
        ev = 0; ed = 0; er = 0; ee = 0;
        if (bad) ee = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else if (m_brk) begin m_brk = 0; m_ext = 0; end
        else begin
            m_ext = 0;
            if (b == 8'h5A) ed = 1;
            else if (b == 8'h76) er = 1;
            else begin ev = 1; m_data = b; end
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input bit flip);
        int v0, d0, r0, e0, ev, ed, er, ee;
        v0 = n_valid; d0 = n_done; r0 = n_rst; e0 = n_err;
        model(b, flip, ev, ed, er, ee);
        send_bits(frame_bits(b, flip), 11);
        wait_clk(40);
        chk({tag, ".valid"}, n_valid - v0, ev);
        chk({tag, ".done"},  n_done - d0, ed);
        chk({tag, ".reset"}, n_rst - r0, er);
        chk({tag, ".err"},   n_err - e0, ee);
        chk({tag, ".data"},  ps2_data_o, m_data);
        if (ev + ed + er + ee > 0)
            chk({tag, ".lat_ok"}, (t_any - t_fall >= 4 && t_any - t_fall <= 10), 1);
    endtask

    initial begin
        int e0, v0;
        logic [7:0] b;
        bit flip;

        wait_clk(5);
        chk("reset_outputs", {ps2_data_o, ps2_valid_o, ps2_done_o, ps2_reset_o, frame_err_o}, 12'h000);
        @(negedge clk) rst = 1'b1;
        wait_clk(20);

        run_frame("make_1c", 8'h1C, 0);
        run_frame("brk_f0", 8'hF0, 0);
        run_frame("brk_1c", 8'h1C, 0);
        run_frame("after_brk_1c", 8'h1C, 0);
        run_frame("enter", 8'h5A, 0);
        run_frame("esc", 8'h76, 0);
        run_frame("ext_e0", 8'hE0, 0);
        run_frame("ext_enter", 8'h5A, 0);
        run_frame("parity_bad", 8'h1C, 1);
        run_frame("good_2d", 8'h2D, 0);

        // Timeout mid-frame after a break prefix: break flag must survive.
        run_frame("pre_to_f0", 8'hF0, 0);
        e0 = n_err;
        send_bits(frame_bits(8'h1C, 0), 5);
        wait_clk(TIMEOUT + 200);
        chk("timeout.err", n_err - e0, 1);
        chk("timeout.lat_ok", (t_any - t_fall >= TIMEOUT + 2 && t_any - t_fall <= TIMEOUT + 14), 1);
        run_frame("to_brk_1c", 8'h1C, 0);
        run_frame("good_33", 8'h33, 0);

        // Glitch shorter than the filter, then a long low seen as a lone bad start.
        e0 = n_err; v0 = n_valid;
        @(negedge clk) ps2_clk_i = 1'b0;
        wait_clk(3);
        ps2_clk_i = 1'b1;
        wait_clk(40);
        chk("glitch.err", n_err - e0, 0);
        chk("glitch.valid", n_valid - v0, 0);
        @(negedge clk) ps2_clk_i = 1'b0;
        wait_clk(6);
        ps2_clk_i = 1'b1;
        wait_clk(40);
        chk("long_low.err", n_err - e0, 1);

        // Reset mid-frame with break flag set and a nonzero held byte.
        run_frame("pre_rst_f0", 8'hF0, 0);
        send_bits(frame_bits(8'h1C, 0), 5);
        wait_clk(7);
        rst = 1'b0;
        #1;
        chk("midrst_outputs", {ps2_data_o, ps2_valid_o, ps2_done_o, ps2_reset_o, frame_err_o}, 12'h000);
        m_brk = 0; m_ext = 0; m_data = 8'h00;
        wait_clk(10);
        rst = 1'b1;
        wait_clk(20);
        run_frame("post_rst_1c", 8'h1C, 0);

        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 7))
                0: b = 8'hF0;
                1: b = 8'hE0;
                2: b = 8'h5A;
                3: b = 8'h76;
                default: b = 8'($urandom_range(0, 255));
            endcase
            flip = ($urandom_range(0, 5) == 0);
            run_frame($sformatf("rnd%0d", i), b, flip);
        end

        chk("strobe_exclusive", n_excl, 0);
        chk("strobe_one_cycle", n_wide, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
